// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - default PHT index width
//   - pipelined prediction record {valid, pred, idx} carried D->E->M
//   - saturating counter update helper
package bp_pkg;

  localparam int BP_PHT_IDX_W = 6;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  // The idx field is sized by the package default, so a design built with a
  // different index width must change BP_PHT_IDX_W here as well.
  typedef struct packed {
    logic                    valid;
    logic                    pred;
    logic [BP_PHT_IDX_W-1:0] idx;
  } pred_rec_t;

  localparam pred_rec_t REC_BUBBLE = '{valid: 1'b0, pred: 1'b0, idx: '0};

  // Saturating 2-bit step: never wraps past ST or below SNT.
  function automatic logic [1:0] cnt_upd(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) nxt = (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
    else       nxt = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/pht_bank.sv
// Pattern history table: 2^IDX_W entries of 2-bit saturating counters.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (all entries -> CNT_INIT)
//   rd_idx_i        combinational read index
//   rd_cnt_o        counter at rd_idx_i (pre-update value, no write bypass)
//   wr_en_i         train the entry at wr_idx_i this edge
//   wr_idx_i        entry to train
//   wr_taken_i      resolved outcome: increment if 1, decrement if 0
module pht_bank
  import bp_pkg::*;
#(
  parameter int         IDX_W    = BP_PHT_IDX_W,
  parameter logic [1:0] CNT_INIT = CNT_WNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] cnt_q [DEPTH];
  logic [1:0] cnt_d [DEPTH];

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en_i) cnt_d[wr_idx_i] = cnt_upd(cnt_q[wr_idx_i], wr_taken_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor feeding the pipeline hazard unit.
// Predicts in D from a PHT of 2-bit counters, carries {valid, pred, idx}
// through E and M (honouring flushE/flushM) and trains the PHT in M.
// Optional feature: define BP_GSHARE_EN to XOR a non-speculative global
// history register into the PHT index (gshare); default build is bimodal.
// Ports:
//   clk, resetn     core clock, asynchronous active-low reset
//   pcD, branchD    PC of the D instruction and its is-conditional-branch flag
//   flushE, flushM  hazard-unit bubbles into the E / M prediction registers
//   actual_takeM    resolved outcome of the M-stage branch
//   pred_takeD      predict-taken for the D branch (combinational)
//   pred_resM       M-stage branch was mispredicted (combinational)
//   pred_takeM      prediction that was made for the M-stage branch
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         PHT_IDX_W = BP_PHT_IDX_W,
  parameter logic [1:0] CNT_INIT  = CNT_WNT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pcD,
  input  logic        branchD,
  input  logic        flushE,
  input  logic        flushM,
  input  logic        actual_takeM,
  output logic        pred_takeD,
  output logic        pred_resM,
  output logic        pred_takeM
);

  logic [PHT_IDX_W-1:0] pc_idx;
  logic [PHT_IDX_W-1:0] idxD;
  logic [1:0]           cntD;
  pred_rec_t            recE_q, recE_d;
  pred_rec_t            recM_q, recM_d;

  assign pc_idx = pcD[PHT_IDX_W+1:2];

`ifdef BP_GSHARE_EN
  // History advances only when a branch resolves, so it never needs repair.
  logic [PHT_IDX_W-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (recM_q.valid) ghr_d = {ghr_q[PHT_IDX_W-2:0], actual_takeM};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ghr_q <= '0;
    else         ghr_q <= ghr_d;
  end

  // The hashed index is what travels down the pipe, so training hits the
  // same entry that produced the prediction even if GHR moved meanwhile.
  assign idxD = pc_idx ^ ghr_q;
`else
  assign idxD = pc_idx;
`endif

  // PC bits outside the index and the counter LSB do not affect prediction.
  logic unused_bits;
  assign unused_bits = ^{pcD[31:PHT_IDX_W+2], pcD[1:0], cntD[0]};

  pht_bank #(
    .IDX_W    (PHT_IDX_W),
    .CNT_INIT (CNT_INIT)
  ) u_pht (
    .clk        (clk),
    .rst_n      (resetn),
    .rd_idx_i   (idxD),
    .rd_cnt_o   (cntD),
    .wr_en_i    (recM_q.valid),
    .wr_idx_i   (recM_q.idx),
    .wr_taken_i (actual_takeM)
  );

  assign pred_takeD = branchD & cntD[1];

  always_comb begin
    recE_d = REC_BUBBLE;
    if (!flushE) recE_d = '{valid: branchD, pred: pred_takeD, idx: idxD};
  end

  // flushM is driven from pred_resM by the hazard unit, which bubbles M on
  // the following cycle and keeps the mispredict a single-cycle pulse.
  always_comb begin
    recM_d = REC_BUBBLE;
    if (!flushM) recM_d = recE_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      recE_q <= REC_BUBBLE;
      recM_q <= REC_BUBBLE;
    end else begin
      recE_q <= recE_d;
      recM_q <= recM_d;
    end
  end

  assign pred_resM  = recM_q.valid & (recM_q.pred != actual_takeM);
  assign pred_takeM = recM_q.valid & recM_q.pred;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor. The hazard unit is
// modelled by feeding pred_resM back into flushM each cycle. With
// BP_GSHARE_EN defined a gshare-specific sequence runs instead.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pcD;
  logic        branchD, flushE, flushM, actual_takeM;
  logic        pred_takeD, pred_resM, pred_takeM;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PC_A     = 32'h0040_0010; // idx 4
  localparam logic [31:0] PC_ALIAS = 32'h0040_0110; // also idx 4
  localparam logic [31:0] PC_B     = 32'h0040_0000; // idx 0

  branch_predictor dut (
    .clk          (clk),
    .resetn       (resetn),
    .pcD          (pcD),
    .branchD      (branchD),
    .flushE       (flushE),
    .flushM       (flushM),
    .actual_takeM (actual_takeM),
    .pred_takeD   (pred_takeD),
    .pred_resM    (pred_resM),
    .pred_takeM   (pred_takeM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: apply inputs at negedge, then hazard-unit feedback.
  task automatic drive(input logic br, input logic [31:0] pc, input logic fe, input logic at);
    @(negedge clk);
    branchD = br; pcD = pc; flushE = fe; actual_takeM = at;
    #1;
    flushM = pred_resM;
    #1;
  endtask

  initial begin
    resetn = 1'b0; branchD = 1'b1; pcD = PC_A;
    flushE = 1'b0; flushM = 1'b0; actual_takeM = 1'b0;
    #12;
    chk("rst_pred_takeD", {7'd0, pred_takeD}, 8'd0);
    chk("rst_pred_resM",  {7'd0, pred_resM},  8'd0);
    chk("rst_pred_takeM", {7'd0, pred_takeM}, 8'd0);
    chk("rst_pht4",       {6'd0, dut.u_pht.cnt_q[4]},  8'd1);
    chk("rst_pht63",      {6'd0, dut.u_pht.cnt_q[63]}, 8'd1);
    @(negedge clk);
    branchD = 1'b0;
    resetn  = 1'b1;

`ifdef BP_GSHARE_EN
    drive(1, PC_B, 0, 0);                                  // idx 0
    chk("g_pred0", {7'd0, pred_takeD}, 8'd0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);                                     // T
    chk("g_res0", {7'd0, pred_resM}, 8'd1);
    drive(1, PC_B, 0, 0);                                  // idx 0^1
    chk("g_ghr1", {2'd0, dut.ghr_q}, 8'd1);
    chk("g_pht0", {6'd0, dut.u_pht.cnt_q[0]}, 8'd2);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);                                     // T
    drive(1, PC_B, 0, 0);                                  // idx 0^3
    chk("g_pht1", {6'd0, dut.u_pht.cnt_q[1]}, 8'd2);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);                                     // N
    chk("g_res2", {7'd0, pred_resM}, 8'd0);
    drive(1, PC_A, 0, 0);                                  // idx 4^6 = 2
    chk("g_ghr6", {2'd0, dut.ghr_q}, 8'h06);
    chk("g_pht3", {6'd0, dut.u_pht.cnt_q[3]}, 8'd0);
    chk("g_predA", {7'd0, pred_takeD}, 8'd0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("g_resA", {7'd0, pred_resM}, 8'd1);
    drive(0, 0, 0, 0);
    chk("g_pht2", {6'd0, dut.u_pht.cnt_q[2]}, 8'd2);
    chk("g_pht4", {6'd0, dut.u_pht.cnt_q[4]}, 8'd1);
    chk("g_ghr13", {2'd0, dut.ghr_q}, 8'h0d);
`else
    // c0..c5: first taken resolution, mispredict pulse, retrain
    drive(1, PC_A, 0, 0);
    chk("c0_pred", {7'd0, pred_takeD}, 8'd0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("c2_res",   {7'd0, pred_resM},  8'd1);
    chk("c2_takeM", {7'd0, pred_takeM}, 8'd0);
    drive(1, PC_A, 0, 0);
    chk("c3_res_pulse", {7'd0, pred_resM}, 8'd0);
    chk("c3_pht4", {6'd0, dut.u_pht.cnt_q[4]}, 8'd2);
    chk("c3_pred", {7'd0, pred_takeD}, 8'd1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("c5_res",   {7'd0, pred_resM},  8'd0);
    chk("c5_takeM", {7'd0, pred_takeM}, 8'd1);
    // c6..c10: saturation at ST
    drive(1, PC_A, 0, 0);
    chk("c6_pht4", {6'd0, dut.u_pht.cnt_q[4]}, 8'd3);
    drive(1, PC_A, 0, 0);
    drive(0, PC_A, 0, 1);
    chk("c8_nobranch", {7'd0, pred_takeD}, 8'd0);
    drive(0, 0, 0, 1);
    chk("c9_takeM", {7'd0, pred_takeM}, 8'd1);
    drive(1, PC_A, 0, 0);
    chk("c10_pht4_sat", {6'd0, dut.u_pht.cnt_q[4]}, 8'd3);
    // c11: aliased PC reads idx 4, flushed so never tracked
    drive(1, PC_ALIAS, 1, 0);
    chk("c11_alias", {7'd0, pred_takeD}, 8'd1);
    // c12: not-taken resolution 11 -> 10
    drive(0, 0, 0, 0);
    chk("c12_res", {7'd0, pred_resM}, 8'd1);
    chk("c12_takeM", {7'd0, pred_takeM}, 8'd1);
    // c13..c16: branch with flushE is dropped
    drive(1, PC_A, 1, 0);
    chk("c13_pht4", {6'd0, dut.u_pht.cnt_q[4]}, 8'd2);
    chk("c13_pred", {7'd0, pred_takeD}, 8'd1);
    chk("c13_res",  {7'd0, pred_resM},  8'd0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("c15_flushE_res",   {7'd0, pred_resM},  8'd0);
    chk("c15_flushE_takeM", {7'd0, pred_takeM}, 8'd0);
    drive(0, 0, 0, 0);
    chk("c16_pht4", {6'd0, dut.u_pht.cnt_q[4]}, 8'd2);
    // c17..c20: same-index read during training sees old value
    drive(1, PC_A, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, PC_A, 0, 0);
    chk("c19_res",      {7'd0, pred_resM},  8'd1);
    chk("c19_pred_old", {7'd0, pred_takeD}, 8'd1);
    drive(1, PC_A, 0, 0);
    chk("c20_pred_new", {7'd0, pred_takeD}, 8'd0);
    chk("c20_pht4", {6'd0, dut.u_pht.cnt_q[4]}, 8'd1);
    chk("c20_res",  {7'd0, pred_resM},  8'd0);
    // c21..c23: flushM kills the younger branch sitting in E
    drive(0, 0, 0, 0);
    chk("c21_res", {7'd0, pred_resM}, 8'd1);
    drive(0, 0, 0, 1);
    chk("c22_bubble_res",   {7'd0, pred_resM},  8'd0);
    chk("c22_bubble_takeM", {7'd0, pred_takeM}, 8'd0);
    chk("c22_pht4", {6'd0, dut.u_pht.cnt_q[4]}, 8'd0);
    drive(0, 0, 0, 0);
    chk("c23_pht4_killed", {6'd0, dut.u_pht.cnt_q[4]}, 8'd0);
    // c24..c27: saturation at SNT
    drive(1, PC_A, 0, 0);
    chk("c24_pred", {7'd0, pred_takeD}, 8'd0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("c26_res", {7'd0, pred_resM}, 8'd0);
    drive(0, 0, 0, 0);
    chk("c27_pht4_sat0", {6'd0, dut.u_pht.cnt_q[4]}, 8'd0);
    // c28..c30: asynchronous reset mid-operation
    drive(1, PC_A, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("c30_res", {7'd0, pred_resM}, 8'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_res",   {7'd0, pred_resM},  8'd0);
    chk("mid_rst_takeM", {7'd0, pred_takeM}, 8'd0);
    chk("mid_rst_pht4",  {6'd0, dut.u_pht.cnt_q[4]}, 8'd1);
    @(negedge clk);
    flushM = 1'b0;
    resetn = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Produces the branch-prediction handshake consumed by the pipeline hazard unit.
  - pred_takeD: D-stage "predicted taken" request.
  - pred_resM: M-stage misprediction pulse.
- Holds a pattern history table (PHT) of 2-bit saturating counters.
- Carries each branch's prediction and PHT index down D→E→M, obeying the hazard unit's flushE/flushM.
- Trains the PHT when the branch resolves in M.

Parameters:
- PHT_IDX_W, 6, PHT index width; the PHT has 2^PHT_IDX_W entries.
- CNT_INIT, 2'b01, counter value after reset (weakly not taken).

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- pcD  in  32  PC of the instruction in D
- branchD  in  1  instruction in D is a conditional branch
- flushE  in  1  from hazard unit; loads a bubble into the E-stage prediction register
- flushM  in  1  from hazard unit; loads a bubble into the M-stage prediction register
- actual_takeM  in  1  branch outcome resolved in M (valid when the M entry is a branch)
- pred_takeD  out  1  predict taken for the D branch (combinational)
- pred_resM  out  1  the M-stage branch was mispredicted (combinational)
- pred_takeM  out  1  the prediction that was made for the M-stage branch, for redirect-PC selection

Behaviour:
- Reset (resetn=0, asynchronous):
  - all PHT counters = CNT_INIT;
  - E/M registers hold valid=0, pred=0, idx=0;
  - GHR = 0.
  - As a result, pred_takeD=0 (CNT_INIT[1]=0), pred_resM=0 and pred_takeM=0 until a branch is seen.
- Reset asserted mid-operation clears all of the above immediately; no partial update survives.
- Index (default): idxD = pcD[PHT_IDX_W+1:2].
- Prediction: pred_takeD = branchD & PHT[idxD][1]. Zero-cycle latency, combinational read.
- D→E register, every clock edge:
  - flushE=1: valid=0, pred=0;
  - otherwise: {valid, pred, idx} <= {branchD, pred_takeD, idxD}.
  - There is no stallE; a load-use stall reaches this block as flushE.
- E→M register, every clock edge:
  - flushM=1: bubble (valid=0, pred=0);
  - otherwise: copy the E register.
- Misprediction: pred_resM = validM & (predM != actual_takeM).
  - The hazard unit drives flushM from pred_resM, so the next cycle holds a bubble in M.
  - pred_resM is therefore a one-cycle pulse per branch and must never repeat for the same branch.
- pred_takeM = validM & predM.
- Training (validM=1, at the clock edge):
  - taken: PHT[idxM] saturating increment (00→01→10→11, stays at 11);
  - not taken: saturating decrement (stays at 00).
  - The branch trains exactly once, whether or not it was mispredicted.
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. The prediction is the counter MSB.
- Simultaneous read and write of the same index: the D read returns the pre-update value; there is no bypass.
- Branch in D while flushE=1: no entry is tracked, and the PHT is never trained for it.
- PHT writes happen only on validM. Bubbles never modify state.
- All arithmetic is on 2 bits with saturation and never wraps.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - adds a PHT_IDX_W-bit global history register (GHR);
  - idxD = pcD[PHT_IDX_W+1:2] ^ GHR;
  - when validM: GHR <= {GHR[PHT_IDX_W-2:0], actual_takeM}. This is non-speculative history, updated at resolution only.
  - GHR resets to 0.
  - The XORed index is what gets pipelined, so training hits the same entry that produced the prediction.
- Not defined:
  - no GHR flops;
  - purely bimodal PC indexing as above.

Decomposition:
- Package bp_pkg holds:
  - counter encodings (SNT/WNT/WT/ST);
  - default PHT_IDX_W;
  - the typedef for the pipelined prediction record {valid, pred, idx}.
- Sub-module pht_bank:
  - 2^PHT_IDX_W × 2-bit array with async reset;
  - one combinational read port;
  - one write port with the saturating update logic.
- branch_predictor holds the D/E/M registers, index formation and the GHR.

Test Plan:
1. Reset, then branchD=1, pcD=0x00400010 → pred_takeD=0; idx 4 reads 01.
2. Taken branch at pcD=0x00400010 resolved taken in M (actual_takeM=1) → pred_resM=1 for exactly one cycle; PHT[4]=10; the same PC next time gives pred_takeD=1.
3. Four consecutive taken resolutions at idx 4 → counter saturates at 11. One not-taken resolution → 10, and the prediction is still taken.
4. Branch in D with flushE=1 the same cycle → validE=0; three cycles later pred_resM=0 and PHT is unchanged.
5. Branch in M trains idx 4 while D reads idx 4 the same cycle → pred_takeD reflects the old counter; the next cycle reflects the new one.
6. With BP_GSHARE_EN: outcomes T,T,N → GHR=6'b000110. pcD=0x00400010 then indexes entry 4^6=2, and training lands on entry 2.
